spi_slave_regfile: RTL and testbench

- SPI mode-0 responder register file: the far end of the SPI link driven by the AHB-Lite-to-SPI bridge.
- Oversamples SCLK/CS_N/MOSI in the HCLK domain and decodes 40-bit frames: 8-bit command then 32-bit data.
- Holds DEPTH 32-bit registers, readable and writable over SPI and from a local SoC-side port.
- Serves as the bridge's bench slave and as a reusable peripheral front end.

---
 rtl/spi_slave_regfile.sv | 162 ++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder with a DEPTH x 32-bit register file, oversampled in the HCLK domain.
// Frames are an 8-bit command (bit7 = write, bits6:0 = address) followed by 32 data bits, MSB first.
module spi_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              lcl_we,
  input  logic [ADDR_W-1:0] lcl_addr,
  input  logic [31:0]       lcl_wdata,
  output logic [31:0]       lcl_rdata,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              addr_err,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  state_t r_state, w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [31:0]            r_regs [DEPTH];
  logic [30:0]            r_rx;
  logic [31:0]            r_tx;
  logic [5:0]             r_cnt;
  logic                   r_wr, r_addr_ok, r_miso, r_miso_oe;
  logic [ADDR_W-1:0]      r_addr;

  logic        w_sclk, w_cs_n, w_mosi;
  logic        w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic        w_abort, w_shift, w_decode, w_commit;
  logic [7:0]  w_cmd;
  logic        w_cmd_ok;
  logic [31:0] w_rx_word, w_snap;

  // Synchroniser and edge-delay flops stay unreset so a frame already in progress
  // when rst drops is seen as "cs_n low without a fall" and is skipped.
  always_ff @(posedge HCLK) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_rise   = w_cs_n & ~r_cs_d;
  assign w_cs_fall   = ~w_cs_n & r_cs_d;

  // NOTE: state and datapath flops use non-blocking assignment so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge HCLK) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output is given a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_next = CMD;
               else if (!w_cs_n) w_next = WAIT_CS;
      CMD:     if (w_cs_rise) w_next = IDLE;
               else if (w_sclk_rise && r_cnt == 6'd7) w_next = DATA;
      DATA:    if (w_cs_rise) w_next = IDLE;
               else if (w_sclk_rise && r_cnt == 6'd39) w_next = WAIT_CS;
      WAIT_CS: if (w_cs_n) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_abort   = 1'b0;
    w_shift   = 1'b0;
    w_decode  = 1'b0;
    w_commit  = 1'b0;
    w_cmd     = {r_rx[6:0], w_mosi};
    w_rx_word = {r_rx, w_mosi};
    w_cmd_ok  = ({25'd0, w_cmd[6:0]} < 32'(DEPTH));
    w_snap    = '0;
    if (r_state == CMD || r_state == DATA) begin
      w_abort = w_cs_rise;
      w_shift = w_sclk_rise && !w_cs_rise;
    end
    w_decode = w_shift && (r_state == CMD) && (r_cnt == 6'd7);
    w_commit = w_shift && (r_state == DATA) && (r_cnt == 6'd39) && r_wr && r_addr_ok;
    if (w_cmd_ok && !w_cmd[7]) w_snap = r_regs[w_cmd[ADDR_W-1:0]];
  end

  always_ff @(posedge HCLK) begin
    if (rst) begin
      // NOTE: the register file is reset entry by entry because software relies on
      // every register reading 0 after reset; this keeps it in flops, not RAM.
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_addr_ok <= 1'b0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
      lcl_rdata <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      addr_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      addr_err  <= 1'b0;
      frame_err <= w_abort;
      r_miso_oe <= ~w_cs_n;
      lcl_rdata <= r_regs[lcl_addr];
      // SPI commit is written last so it wins a same-address collision with lcl_we.
      if (lcl_we) r_regs[lcl_addr] <= lcl_wdata;
      if (w_commit) begin
        r_regs[r_addr] <= w_rx_word;
        wr_stb         <= 1'b1;
        wr_addr        <= r_addr;
        wr_data        <= w_rx_word;
      end
      if (r_state == IDLE) r_cnt <= '0;
      if (w_shift) begin
        r_rx  <= w_rx_word[30:0];
        r_cnt <= r_cnt + 6'd1;
      end
      if (w_decode) begin
        r_wr      <= w_cmd[7];
        r_addr    <= w_cmd[ADDR_W-1:0];
        r_addr_ok <= w_cmd_ok;
        r_tx      <= w_snap;
        addr_err  <= ~w_cmd_ok;
      end
      if (r_state != DATA) begin
        r_miso <= 1'b0;
      end else if (w_sclk_fall) begin
        r_miso <= r_tx[31];
        r_tx   <= {r_tx[30:0], 1'b0};
      end
    end
  end

  assign miso    = r_miso & r_miso_oe;
  assign miso_oe = r_miso_oe;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: stimulus pushes expected events, monitors pop and compare.
// The reference model is a plain array updated by the SPI/local access rules.
module tb_spi_slave_regfile;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int H     = 60;   // SCLK half period in ns (HCLK = 10 ns, 12x oversampling)

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          HCLK = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, miso_oe;
  logic          lcl_we = 1'b0;
  logic [AW-1:0] lcl_addr = '0;
  logic [31:0]   lcl_wdata = '0;
  logic [31:0]   lcl_rdata;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          addr_err, frame_err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [DEPTH];
  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  int          aerr_pend = 0;
  int          ferr_pend = 0;

  spi_slave_regfile #(.DEPTH(DEPTH), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata), .lcl_rdata(lcl_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .addr_err(addr_err), .frame_err(frame_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_lcl_rdata", lcl_rdata, 32'd0);
    check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
  endtask

  // Raw pin wiggling; rst_at >= 0 pulses rst after that many bits.
  task automatic spi_bits(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                          input int rst_at);
    logic [39:0] f;
    f = {cmd, data};
    @(negedge HCLK);
    cs_n = 1'b0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #(30);
        check_reset_outputs();
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
      end
      mosi = f[39-i];
      #(H);
      sclk = 1'b1;
      #(H);
      sclk = 1'b0;
    end
    #(H);
    cs_n = 1'b1;
    mosi = 1'b0;
    #(4*H);
  endtask

  // Issue one frame and record what the DUT must produce for it.
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits);
    int  a;
    bit  ok;
    wr_t w;
    a  = int'(cmd[6:0]);
    ok = (a < DEPTH);
    if (nbits >= 8 && !ok) aerr_pend++;
    if (nbits < 40) begin
      ferr_pend++;
    end else if (cmd[7]) begin
      if (ok) begin
        model[a] = data;
        w.a = AW'(a);
        w.d = data;
        exp_wr.push_back(w);
      end
    end else begin
      exp_rd.push_back(ok ? model[a] : 32'd0);
    end
    spi_bits(cmd, data, nbits, -1);
  endtask

  task automatic lcl_write(input int a, input logic [31:0] d);
    @(negedge HCLK);
    lcl_addr  = AW'(a);
    lcl_wdata = d;
    lcl_we    = 1'b1;
    @(negedge HCLK);
    lcl_we    = 1'b0;
    model[a]  = d;
  endtask

  task automatic lcl_read(input int a, input string name);
    @(negedge HCLK);
    lcl_addr = AW'(a);
    @(posedge HCLK);
    #1;
    check(name, lcl_rdata, model[a]);
  endtask

  // Strobe monitor: write commits, error pulses, and miso quiet while deselected.
  initial begin
    wr_t w;
    forever begin
      @(negedge HCLK);
      if (!miso_oe) check("miso_when_oe_low", {31'd0, miso}, 32'd0);
      if (wr_stb) begin
        check("wr_stb_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", {28'd0, wr_addr}, {28'd0, w.a});
          check("wr_data", wr_data, w.d);
        end
      end
      if (addr_err) begin
        check("addr_err_expected", {31'd0, aerr_pend > 0}, 32'd1);
        if (aerr_pend > 0) aerr_pend--;
      end
      if (frame_err) begin
        check("frame_err_expected", {31'd0, ferr_pend > 0}, 32'd1);
        if (ferr_pend > 0) ferr_pend--;
      end
    end
  end

  // SPI bus monitor: acts as the master's receiver, sampling miso on each sclk rise.
  initial begin
    int          nb;
    logic [7:0]  cb;
    logic [31:0] rd;
    forever begin
      @(negedge cs_n);
      nb = 0;
      cb = '0;
      rd = '0;
      while (1) begin
        @(posedge sclk or posedge cs_n);
        if (cs_n) break;
        if (nb < 8) cb = {cb[6:0], mosi};
        else        rd = {rd[30:0], miso};
        nb++;
      end
      if (nb == 40 && !cb[7]) begin
        check("rd_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
        if (exp_rd.size() > 0) check("miso_word", rd, exp_rd.pop_front());
      end
    end
  end

  initial begin
    bit seen;
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    repeat (6) @(negedge HCLK);
    check_reset_outputs();
    rst = 1'b0;
    repeat (4) @(negedge HCLK);

    // Write/read round trips to addresses 0 and 1.
    do_frame(8'h80, 32'hA5A5_A5A5, 40);
    do_frame(8'h00, 32'h0, 40);
    lcl_read(0, "lcl_reg0_a5");
    do_frame(8'h81, 32'h5A5A_5A5A, 40);
    do_frame(8'h01, 32'h0, 40);
    lcl_read(0, "lcl_reg0_kept");
    lcl_read(1, "lcl_reg1_5a");

    // Aborted frame, then a normal one to the same address.
    do_frame(8'h82, 32'hCAFE_F00D, 20);
    lcl_read(2, "lcl_reg2_after_abort");
    do_frame(8'h82, 32'h7777_1234, 40);
    lcl_read(2, "lcl_reg2_after_full");

    // Out-of-range address: read returns zeros, write discarded.
    do_frame(8'h10, 32'h0, 40);
    do_frame(8'h90, 32'hFFFF_FFFF, 40);
    lcl_read(0, "lcl_reg0_after_bad_wr");

    // Snapshot isolation: local write during the read's data phase.
    lcl_write(3, 32'h1234_5678);
    fork
      do_frame(8'h03, 32'h0, 40);
      begin
        #(20 * 2 * H);
        lcl_write(3, 32'hDEAD_BEEF);
      end
    join
    lcl_read(3, "lcl_reg3_deadbeef");
    do_frame(8'h03, 32'h0, 40);

    // Collision: lcl_we to addr 4 held until the SPI commit strobe is seen.
    fork
      do_frame(8'h84, 32'h1111_1111, 40);
      begin
        lcl_addr  = 4'd4;
        lcl_wdata = 32'h2222_2222;
        lcl_we    = 1'b1;
        seen      = 1'b0;
        for (int k = 0; k < 3000; k++) begin
          @(posedge HCLK);
          #1;
          if (wr_stb) begin
            seen = 1'b1;
            break;
          end
        end
        lcl_we = 1'b0;
        check("coll_wr_stb_seen", {31'd0, seen}, 32'd1);
      end
    join
    lcl_read(4, "lcl_reg4_spi_wins");

    // Reset in the middle of a write frame: no commit, registers cleared.
    spi_bits(8'h85, 32'h5555_AAAA, 40, 20);
    lcl_read(5, "lcl_reg5_after_rst");
    lcl_read(4, "lcl_reg4_after_rst");
    do_frame(8'h85, 32'h0BAD_CAFE, 40);
    do_frame(8'h05, 32'h0, 40);

    // Randomized mix of frames, aborts, local writes and local reads.
    for (int it = 0; it < 40; it++) begin
      int          r, a, nb;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      d = $urandom;
      if (r < 2) begin
        lcl_write($urandom_range(0, DEPTH - 1), d);
      end else begin
        a  = $urandom_range(0, 19);
        nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 39) : 40;
        do_frame({1'($urandom_range(0, 1)), 7'(a)}, d, nb);
      end
      lcl_read($urandom_range(0, DEPTH - 1), "lcl_rand");
    end

    repeat (50) @(negedge HCLK);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("addr_err_drained", aerr_pend, 32'd0);
    check("frame_err_drained", ferr_pend, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
